// File: rtl/sync_fifo_thresh_if.sv
// Handshake/status bundle for sync_fifo_thresh. The master drives requests;
// the slave (the FIFO) drives data and status.
interface sync_fifo_thresh_if #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 7
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en, data_in, err_clr,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, data_in, err_clr,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with any DEPTH >= 2, threshold flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is registered read.
module sync_fifo_thresh #(
  parameter int DEPTH      = 7,
  parameter int DATA_WIDTH = 6,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_thresh_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_thresh: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_thresh: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_thresh: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ov_q, ov_d, un_q, un_d;
  logic                  full_w, empty_w, rd_acc, wr_acc;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  always_comb begin
    rd_acc   = bus.rd_en && !empty_w;
    wr_acc   = bus.wr_en && (!full_w || rd_acc);
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    // A coincident set wins over err_clr.
    ov_d = (ov_q && !bus.err_clr) || (bus.wr_en && full_w && !rd_acc);
    un_d = (un_q && !bus.err_clr) || (bus.rd_en && empty_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ov_q     <= 1'b0;
      un_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ov_q     <= ov_d;
      un_q     <= un_d;
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = empty_w ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ov_q;
  assign bus.underflow    = un_q;
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed bench for sync_fifo_thresh (DEPTH=7, DATA_WIDTH=6): a queue model
// predicts accepts, flags and read data; popped words are compared as they emerge.
module tb_sync_fifo_thresh;
  localparam int DEPTH = 7;
  localparam int DW    = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_thresh_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_thresh #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec  = 0;
  int miss = 0;

  logic [DW-1:0] mq[$];   // model contents
  logic [DW-1:0] sb[$];   // words owed by the DUT on data_out
  logic [DW-1:0] mlast;
  bit            mov, mun;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".full"},  32'(bus.full),  32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(bus.almost_full),  32'(n >= DEPTH - 1));
    chk({tag, ".aempty"},32'(bus.almost_empty), 32'(n <= 1));
    chk({tag, ".ovf"},   32'(bus.overflow),  32'(mov));
    chk({tag, ".unf"},   32'(bus.underflow), 32'(mun));
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".dout"},  32'(bus.data_out), (n != 0) ? 32'(mq[0]) : 32'h0);
`else
    chk({tag, ".dout"},  32'(bus.data_out), 32'(mlast));
`endif
  endtask

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0; bus.err_clr = 1'b0;
  endtask

  task automatic step(input string tag, input bit w, input bit r,
                      input logic [DW-1:0] d, input bit c);
    bit racc, wacc;
    bus.wr_en = w; bus.rd_en = r; bus.data_in = d; bus.err_clr = c;
    racc = r && (mq.size() != 0);
    wacc = w && (mq.size() < DEPTH || racc);
    if (c) begin mov = 1'b0; mun = 1'b0; end
    if (w && mq.size() == DEPTH && !racc) mov = 1'b1;
    if (r && mq.size() == 0) mun = 1'b1;
    if (racc) sb.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    @(posedge clk); #1;
    idle_inputs();
    if (racc) mlast = sb.pop_front();
    check_all(tag);
  endtask

  // Reset with every other input active to show reset has priority.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 6'h11; bus.err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    mq.delete(); sb.delete();
    mlast = '0; mov = 1'b0; mun = 1'b0;
    check_all(tag);
  endtask

  logic [DW-1:0] fill [7] = '{6'h2A, 6'h15, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10};

  initial begin
    idle_inputs();
    @(posedge clk); #1;
    do_reset("reset");

    step("rd_empty", 1'b0, 1'b1, '0, 1'b0);

    for (int i = 0; i < DEPTH; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0, fill[i], 1'b0);
    step("overflow", 1'b1, 1'b0, 6'h20, 1'b0);

    for (int i = 0; i < DEPTH; i++)
      step($sformatf("full_rw%0d", i), 1'b1, 1'b1, 6'(8'h21 + i), 1'b0);

    for (int i = 0; i < DEPTH; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1, '0, 1'b0);

    step("err_clr", 1'b0, 1'b0, '0, 1'b1);
    step("clr_vs_set", 1'b0, 1'b1, '0, 1'b1);
    step("empty_rw", 1'b1, 1'b1, 6'h33, 1'b0);
    step("pop_33", 1'b0, 1'b1, '0, 1'b0);
    step("err_clr2", 1'b0, 1'b0, '0, 1'b1);

    for (int i = 0; i < 4; i++) step($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 6'(i + 5), 1'b0);
    do_reset("mid_reset");
    step("wr_3f", 1'b1, 1'b0, 6'h3F, 1'b0);
    step("rd_3f", 1'b0, 1'b1, '0, 1'b0);
    step("rd_after", 1'b0, 1'b1, '0, 1'b0);

    // Pointer wrap at a non-power-of-two offset.
    step("err_clr3", 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++)
      step($sformatf("stream%0d", i), 1'b1, (i % 3) != 0, 6'($urandom_range(0, 63)), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step($sformatf("final%0d", i), 1'b0, 1'b1, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
